viterbi_dec_ctrl: RTL and testbench

- Sequencing controller for the hard-decision Viterbi decoder datapath: 2-bit symbol input, add-compare-select (ACS) path/branch metric unit, and a 15-column circular survivor (decision) memory.
- Accepts symbols via a valid/ready handshake and fires the ACS for each one.
- Writes each decision column into survivor memory, then traces back TB_DEPTH columns from the ACS-reported best state to emit one decoded bit per symbol.
- Configures state count from the runtime constraint length K (3..6).

---
 rtl/viterbi_dec_ctrl_pkg.sv | 55 +++++
 rtl/viterbi_dec_ctrl_if.sv | 42 ++++
 rtl/viterbi_dec_ctrl_surv_addr_ctr.sv | 28 ++
 rtl/viterbi_dec_ctrl.sv | 137 +++++++++++++
 tb/tb_viterbi_dec_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_dec_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// viterbi_pkg
// Shared constants, controller state type and traceback helper functions for
// the hard-decision Viterbi decoder controller.
//   TB_DEPTH : survivor memory columns (= traceback window)
//   MAX_K    : largest supported constraint length
//   SW       : trellis state width (MAX_K-1)
//   AW       : survivor column address width
// ---------------------------------------------------------------------------
package viterbi_pkg;

  localparam int TB_DEPTH = 15;
  localparam int MAX_K    = 6;
  localparam int SW       = MAX_K - 1;
  localparam int NS_MAX   = 1 << SW;
  localparam int AW       = 4;

  localparam logic [2:0]    K_MIN     = 3'd3;
  localparam logic [2:0]    K_MAX     = 3'd6;
  localparam logic [AW-1:0] LAST_COL  = AW'(TB_DEPTH - 1);
  localparam logic [AW-1:0] FULL_FILL = AW'(TB_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_TB
  } ctrl_state_t;

  function automatic logic k_legal(input logic [2:0] k);
    return (k >= K_MIN) && (k <= K_MAX);
  endfunction

  // Mask of the NS = 2^(K-1) live states; illegal K values give an arbitrary
  // mask, which is harmless because no symbol is accepted while K is illegal.
  function automatic logic [SW-1:0] state_mask(input logic [2:0] k);
    logic [SW:0] ns;
    ns = (SW+1)'(1) << (k - 3'd1);
    return SW'(ns - (SW+1)'(1));
  endfunction

  // Predecessor of state s given its decision bit d: the decision supplies
  // the bit shifted out when the encoder moved into s.
  function automatic logic [SW-1:0] pred_state(input logic [SW-1:0] s,
                                               input logic          d,
                                               input logic [2:0]    k);
    logic [SW-1:0] msb;
    msb = SW'(d) << (k - 3'd2);
    return ((s >> 1) | msb) & state_mask(k);
  endfunction

  // Circular decrement of a survivor column address.
  function automatic logic [AW-1:0] wrap_dec(input logic [AW-1:0] addr);
    return (addr == '0) ? LAST_COL : addr - AW'(1);
  endfunction

endpackage

// File: rtl/viterbi_dec_ctrl_if.sv
// ---------------------------------------------------------------------------
// viterbi_dec_ctrl_if
// Bundles everything between the controller and the decoder datapath:
// config (choose_constraint_length, flush), symbol handshake (sym_valid /
// sym_ready), ACS control (acs_en, acs_first, best_state), survivor memory
// write/read ports, decoded output (dec_valid, dec_bit) and status (busy,
// cfg_err).
//   master : the controller
//   slave  : the datapath / environment
// ---------------------------------------------------------------------------
interface viterbi_dec_ctrl_if;
  import viterbi_pkg::*;

  logic [2:0]        choose_constraint_length;
  logic              flush;
  logic              sym_valid;
  logic              sym_ready;
  logic              acs_en;
  logic              acs_first;
  logic              surv_wr_en;
  logic [AW-1:0]     surv_wr_addr;
  logic [SW-1:0]     best_state;
  logic [AW-1:0]     surv_rd_addr;
  logic [NS_MAX-1:0] surv_rd_data;
  logic              dec_valid;
  logic              dec_bit;
  logic              busy;
  logic              cfg_err;

  modport master (
    input  choose_constraint_length, flush, sym_valid, best_state, surv_rd_data,
    output sym_ready, acs_en, acs_first, surv_wr_en, surv_wr_addr,
           surv_rd_addr, dec_valid, dec_bit, busy, cfg_err
  );

  modport slave (
    output choose_constraint_length, flush, sym_valid, best_state, surv_rd_data,
    input  sym_ready, acs_en, acs_first, surv_wr_en, surv_wr_addr,
           surv_rd_addr, dec_valid, dec_bit, busy, cfg_err
  );

endinterface

// File: rtl/viterbi_dec_ctrl_surv_addr_ctr.sv
// ---------------------------------------------------------------------------
// surv_addr_ctr
// Modulo-TB_DEPTH up counter used as the survivor memory write pointer.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   clr   : synchronous clear (stream flush)
//   inc   : advance by one column, wrapping TB_DEPTH-1 -> 0
//   count : current column
// ---------------------------------------------------------------------------
module surv_addr_ctr
  import viterbi_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == LAST_COL) ? '0 : count + AW'(1);
    end
  end

endmodule

// File: rtl/viterbi_dec_ctrl.sv
// ---------------------------------------------------------------------------
// viterbi_dec_ctrl
// Sequencing controller for a hard-decision Viterbi decoder. Accepts one
// symbol per handshake, fires the ACS, writes the decision column into the
// circular survivor memory and, once the window is full, traces back
// TB_DEPTH columns from the ACS best state to emit one decoded bit.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : controller side (master) of viterbi_dec_ctrl_if
// ---------------------------------------------------------------------------
module viterbi_dec_ctrl
  import viterbi_pkg::*;
(
  input logic               clk,
  input logic               rst,
  viterbi_dec_ctrl_if.master bus
);

  ctrl_state_t   state_q, state_d;
  logic [AW-1:0] fill_q, fill_d;
  logic [AW-1:0] tb_cnt_q, tb_cnt_d;     // cycle index inside traceback (1..TB_DEPTH)
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]    k_q, k_d;
  logic [SW-1:0] s_q, s_d;               // traceback state
  logic          dec_valid_q, dec_valid_d;
  logic          dec_bit_q, dec_bit_d;
  logic [AW-1:0] wp;
  logic [SW-1:0] s_mask;
  logic          cfg_err;
  logic          ready;
  logic          accept;

  assign s_mask  = state_mask(k_q);
  assign cfg_err = !k_legal(k_q);
  // flush beats a pending symbol, so the handshake is withheld in that cycle.
  assign ready   = !rst && !bus.flush && (state_q == S_IDLE) && !cfg_err;
  assign accept  = ready && bus.sym_valid;

  surv_addr_ctr u_wp (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.flush),
    .inc   (accept),
    .count (wp)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    fill_d      = fill_q;
    tb_cnt_d    = tb_cnt_q;
    rd_addr_d   = rd_addr_q;
    k_d         = k_q;
    s_d         = s_q;
    dec_valid_d = 1'b0;
    dec_bit_d   = dec_bit_q;

    // K may only change while the stream is empty.
    if ((state_q == S_IDLE) && (fill_q == '0)) begin
      k_d = bus.choose_constraint_length;
    end

    if (bus.flush) begin
      state_d = S_IDLE;
      fill_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            fill_d    = (fill_q == FULL_FILL) ? fill_q : fill_q + AW'(1);
            // The column written now is the newest one, i.e. (wp-1) once wp
            // has advanced; the first traceback read goes there.
            rd_addr_d = wp;
            tb_cnt_d  = AW'(1);
            if (fill_q >= LAST_COL) begin
              state_d = S_TB;
            end
          end
        end
        S_TB: begin
          rd_addr_d = wrap_dec(rd_addr_q);
          tb_cnt_d  = tb_cnt_q + AW'(1);
          // First cycle: ACS best state becomes valid. Later cycles: read data
          // for the address issued one cycle earlier steps to the predecessor.
          if (tb_cnt_q == AW'(1)) begin
            s_d = bus.best_state & s_mask;
          end else begin
            s_d = pred_state(s_q, bus.surv_rd_data[s_q], k_q);
          end
          if (tb_cnt_q == FULL_FILL) begin
            state_d     = S_IDLE;
            dec_valid_d = 1'b1;
            dec_bit_d   = s_d[0];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      fill_q      <= '0;
      tb_cnt_q    <= '0;
      rd_addr_q   <= '0;
      k_q         <= K_MIN;
      s_q         <= '0;
      dec_valid_q <= 1'b0;
      dec_bit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      tb_cnt_q    <= tb_cnt_d;
      rd_addr_q   <= rd_addr_d;
      k_q         <= k_d;
      s_q         <= s_d;
      dec_valid_q <= dec_valid_d;
      dec_bit_q   <= dec_bit_d;
    end
  end

  assign bus.sym_ready    = ready;
  assign bus.acs_en       = accept;
  assign bus.acs_first    = accept && (fill_q == '0);
  assign bus.surv_wr_en   = accept;
  assign bus.surv_wr_addr = wp;
  assign bus.surv_rd_addr = rd_addr_q;
  assign bus.dec_valid    = dec_valid_q;
  assign bus.dec_bit      = dec_bit_q;
  assign bus.busy         = !rst && (state_q == S_TB);
  assign bus.cfg_err      = !rst && cfg_err;

endmodule

// File: tb/tb_viterbi_dec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_viterbi_dec_ctrl
// Bench for viterbi_dec_ctrl. Plays the datapath: a survivor memory with one
// cycle read latency and an ACS that reports best_state the cycle after
// acs_en. Expected decoded bits come from a symbol-history trace using the
// predecessor rule directly; expected addresses come from symbol counts.
// ---------------------------------------------------------------------------
module tb_viterbi_dec_ctrl;
  import viterbi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  viterbi_dec_ctrl_if bus();

  viterbi_dec_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] hist[$];          // decision words accepted since last flush
  int          model_k;
  logic [31:0] mem [TB_DEPTH];
  logic [31:0] cur_word;
  logic [4:0]  cur_best;

  logic       o_sym_ready, o_acs_en, o_acs_first, o_wr_en;
  logic       o_dec_valid, o_dec_bit, o_busy, o_cfg_err;
  logic [3:0] o_wr_addr, o_rd_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample outputs mid-cycle, then act as the datapath.
  task automatic step();
    @(negedge clk);
    o_sym_ready = bus.sym_ready;
    o_acs_en    = bus.acs_en;
    o_acs_first = bus.acs_first;
    o_wr_en     = bus.surv_wr_en;
    o_wr_addr   = bus.surv_wr_addr;
    o_rd_addr   = bus.surv_rd_addr;
    o_dec_valid = bus.dec_valid;
    o_dec_bit   = bus.dec_bit;
    o_busy      = bus.busy;
    o_cfg_err   = bus.cfg_err;
    @(posedge clk);
    #1;
    if (o_wr_en === 1'b1) mem[o_wr_addr] = cur_word;
    bus.surv_rd_data = mem[o_rd_addr];
    bus.best_state   = (o_acs_en === 1'b1) ? cur_best : 5'($urandom);
  endtask

  // Trace back from the newest symbol through its 14 newest decision words.
  function automatic logic model_decode(input int k, input logic [4:0] best);
    int mask, s, d;
    logic [31:0] w;
    mask = (1 << (k - 1)) - 1;
    s = int'(best) & mask;
    for (int j = 0; j < TB_DEPTH - 1; j++) begin
      w = hist[hist.size() - 1 - j];
      d = int'(w[s]);
      s = ((s >> 1) | (d << (k - 2))) & mask;
    end
    return s[0];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_sym_ready"}, o_sym_ready, 0);
    check({tag, "_acs_en"},    o_acs_en,    0);
    check({tag, "_acs_first"}, o_acs_first, 0);
    check({tag, "_wr_en"},     o_wr_en,     0);
    check({tag, "_wr_addr"},   o_wr_addr,   0);
    check({tag, "_rd_addr"},   o_rd_addr,   0);
    check({tag, "_dec_valid"}, o_dec_valid, 0);
    check({tag, "_dec_bit"},   o_dec_bit,   0);
    check({tag, "_busy"},      o_busy,      0);
    check({tag, "_cfg_err"},   o_cfg_err,   0);
  endtask

  // Stream must be empty. Two cycles: one to latch K, one to observe it.
  task automatic set_k(input int k);
    logic legal;
    legal = (k >= 3) && (k <= 6);
    bus.choose_constraint_length = 3'(k);
    bus.sym_valid = 1'b0;
    step();
    bus.sym_valid = !legal;
    step();
    check("cfg_err", o_cfg_err, !legal);
    check("cfg_ready", o_sym_ready, legal);
    check("cfg_acs_en", o_acs_en, 0);
    bus.sym_valid = 1'b0;
    if (legal) model_k = k;
  endtask

  // Flush coinciding with a valid symbol: flush wins.
  task automatic do_flush();
    bus.sym_valid = 1'b1;
    bus.flush     = 1'b1;
    step();
    check("flush_acs_en", o_acs_en, 0);
    check("flush_wr_en", o_wr_en, 0);
    bus.flush     = 1'b0;
    bus.sym_valid = 1'b0;
    hist.delete();
    model_k = int'(bus.choose_constraint_length);
  endtask

  // abort: 0 none, 1 flush at traceback cycle 8, 2 rst at traceback cycle 8
  task automatic run_symbol(input logic [31:0] word, input logic [4:0] best, input int abort);
    int n;
    n = hist.size();
    cur_word = word;
    cur_best = best;
    bus.sym_valid = 1'b1;
    step();
    check("acc_acs_en", o_acs_en, 1);
    check("acc_wr_en", o_wr_en, 1);
    check("acc_wr_addr", o_wr_addr, 32'(n % TB_DEPTH));
    check("acc_acs_first", o_acs_first, (n == 0));
    check("acc_dec_valid", o_dec_valid, 0);
    hist.push_back(word);
    bus.sym_valid = 1'b0;
    if (hist.size() < TB_DEPTH) return;

    if (abort == 0) begin
      for (int c = 1; c <= TB_DEPTH; c++) begin
        bus.sym_valid = 1'($urandom_range(0, 1));
        step();
        check("tb_busy", o_busy, 1);
        check("tb_ready", o_sym_ready, 0);
        check("tb_acs_en", o_acs_en, 0);
        check("tb_dec_valid", o_dec_valid, 0);
        if (c < TB_DEPTH)
          check("tb_rd_addr", o_rd_addr, 32'((((n - c + 1) % TB_DEPTH) + TB_DEPTH) % TB_DEPTH));
      end
      bus.sym_valid = 1'b0;
      step();
      check("out_dec_valid", o_dec_valid, 1);
      check("out_dec_bit", o_dec_bit, model_decode(model_k, best));
      check("out_busy", o_busy, 0);
      check("out_ready", o_sym_ready, 1);
    end else begin
      for (int c = 1; c < 8; c++) begin
        bus.sym_valid = 1'($urandom_range(0, 1));
        step();
        check("ab_busy", o_busy, 1);
      end
      bus.sym_valid = 1'b1;
      if (abort == 1) bus.flush = 1'b1;
      else            rst = 1'b1;
      step();
      check("ab_acs_en", o_acs_en, 0);
      bus.flush     = 1'b0;
      rst           = 1'b0;
      bus.sym_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
        step();
        check("ab_dec_valid", o_dec_valid, 0);
        check("ab_busy", o_busy, 0);
        if (c == 0) check("ab_wr_addr", o_wr_addr, 0);
      end
      hist.delete();
      model_k = int'(bus.choose_constraint_length);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < TB_DEPTH; i++) mem[i] = '0;
    rst = 1'b1;
    bus.sym_valid = 1'b1;
    bus.flush = 1'b0;
    bus.choose_constraint_length = 3'd3;
    bus.best_state = '0;
    bus.surv_rd_data = '0;
    cur_word = '0;
    cur_best = '0;
    model_k = 3;

    // Reset held with a pending symbol.
    repeat (3) begin
      step();
      check_all_zero("rst");
    end
    rst = 1'b0;
    bus.sym_valid = 1'b0;
    step();
    check("rel_ready", o_sym_ready, 1);
    check("rel_cfg_err", o_cfg_err, 0);
    check("rel_acs_en", o_acs_en, 0);

    // K=3: all-zero decisions, best_state 3 -> decoded 0; then wrap to 20.
    set_k(3);
    for (int i = 0; i < TB_DEPTH; i++) run_symbol(32'h0, 5'd3, 0);
    for (int i = 0; i < 5; i++) run_symbol($urandom, 5'($urandom), 0);

    // K=6: all-one decisions, best_state 31 -> decoded 1.
    do_flush();
    set_k(6);
    for (int i = 0; i < TB_DEPTH; i++) run_symbol(32'hFFFF_FFFF, 5'd31, 0);

    // Illegal K, then recovery; mid-stream K change ignored.
    do_flush();
    set_k(7);
    set_k(4);
    for (int i = 0; i < 8; i++) run_symbol($urandom, 5'($urandom), 0);
    bus.choose_constraint_length = 3'd6;
    for (int i = 0; i < 12; i++) run_symbol($urandom, 5'($urandom), 0);

    // Flush mid-traceback, then a fresh stream.
    do_flush();
    set_k(5);
    for (int i = 0; i < TB_DEPTH - 1; i++) run_symbol($urandom, 5'($urandom), 0);
    run_symbol($urandom, 5'($urandom), 1);
    for (int i = 0; i < TB_DEPTH + 2; i++) run_symbol($urandom, 5'($urandom), 0);

    // Reset mid-traceback, then a fresh stream.
    do_flush();
    for (int i = 0; i < TB_DEPTH - 1; i++) run_symbol($urandom, 5'($urandom), 0);
    run_symbol($urandom, 5'($urandom), 2);
    for (int i = 0; i < TB_DEPTH + 1; i++) run_symbol($urandom, 5'($urandom), 0);

    // Random K streams.
    for (int it = 0; it < 3; it++) begin
      do_flush();
      set_k(3 + int'($urandom_range(0, 3)));
      for (int i = 0; i < TB_DEPTH + 2; i++) run_symbol($urandom, 5'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
